process_control: RTL and testbench

- Top-level session sequencer for the console design: login (access control), menu, game, scoreboard.
- Holds the current mode in a Moore FSM and drives the select lines that route shared buttons, switches, LCD and LEDs to the active sub-block.
- Tracks a 16-bit login/session ID and a 4-bit game slot index used by the scoreboard.

---
 rtl/process_control.sv | 104 ++++++++++
 tb/tb_process_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_control.sv
// Top-level session sequencer: login (access control), menu, game and scoreboard modes.
// Routes the shared buttons, switches, LCD and LEDs to the active sub-block and tracks session and game slot.
module process_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  buttons,
    input  logic        access_control_fb,
    input  logic        game_fb,
    input  logic        scoreboard_fb,
    output logic [2:0]  buttons_select,
    output logic        switches_select,
    output logic [2:0]  lcd_control,
    output logic [1:0]  led_control,
    output logic [15:0] userid,
    output logic [3:0]  game_score_select
);

    typedef enum logic [1:0] {
        ACCESS     = 2'b00,
        MENU       = 2'b01,
        GAME       = 2'b10,
        SCOREBOARD = 2'b11
    } state_t;

    state_t state;

    logic buttons_idle;
    assign buttons_idle = (buttons == 3'b000);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ACCESS;
            userid            <= 16'h0000;
            game_score_select <= 4'h0;
        end else begin
            case (state)
                ACCESS: begin
                    if (access_control_fb && buttons_idle) begin
                        state             <= MENU;
                        userid            <= userid + 16'd1;
                        game_score_select <= 4'h0;
                    end
                end
                MENU: begin
                    // Logout wins over any other button held at the same time.
                    if (buttons[2])
                        state <= ACCESS;
                    else if (buttons[0])
                        state <= GAME;
                    else if (buttons[1])
                        state <= SCOREBOARD;
                end
                GAME: begin
                    if (game_fb && buttons_idle) begin
                        state <= MENU;
                        if (game_score_select != 4'hF)
                            game_score_select <= game_score_select + 4'h1;
                    end
                end
                SCOREBOARD: begin
                    if (scoreboard_fb && buttons_idle)
                        state <= MENU;
                end
                default: state <= ACCESS;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so the decode can never infer a latch.
    always_comb begin
        buttons_select  = 3'b001;
        switches_select = 1'b1;
        lcd_control     = 3'b001;
        led_control     = 2'b01;
        case (state)
            MENU: begin
                buttons_select  = 3'b000;
                switches_select = 1'b0;
                lcd_control     = 3'b010;
                led_control     = 2'b00;
            end
            GAME: begin
                buttons_select  = 3'b010;
                switches_select = 1'b0;
                lcd_control     = 3'b011;
                led_control     = 2'b10;
            end
            SCOREBOARD: begin
                buttons_select  = 3'b100;
                switches_select = 1'b0;
                lcd_control     = 3'b100;
                led_control     = 2'b11;
            end
            default: begin
                buttons_select  = 3'b001;
                switches_select = 1'b1;
                lcd_control     = 3'b001;
                led_control     = 2'b01;
            end
        endcase
    end

endmodule

// File: tb/tb_process_control.sv
// Directed bench for process_control: mode transitions, release guard, counters and async reset.
// Decode outputs are compared as one packed vector {buttons_select, switches_select, lcd_control, led_control}.
module tb_process_control;

    logic        clk;
    logic        rst;
    logic [2:0]  buttons;
    logic        access_control_fb;
    logic        game_fb;
    logic        scoreboard_fb;
    logic [2:0]  buttons_select;
    logic        switches_select;
    logic [2:0]  lcd_control;
    logic [1:0]  led_control;
    logic [15:0] userid;
    logic [3:0]  game_score_select;

    localparam logic [8:0] DEC_ACCESS = {3'b001, 1'b1, 3'b001, 2'b01};
    localparam logic [8:0] DEC_MENU   = {3'b000, 1'b0, 3'b010, 2'b00};
    localparam logic [8:0] DEC_GAME   = {3'b010, 1'b0, 3'b011, 2'b10};
    localparam logic [8:0] DEC_SCORE  = {3'b100, 1'b0, 3'b100, 2'b11};

    logic [8:0] dec;
    assign dec = {buttons_select, switches_select, lcd_control, led_control};

    int n_cmp = 0;
    int n_bad = 0;

    process_control dut (
        .clk               (clk),
        .rst               (rst),
        .buttons           (buttons),
        .access_control_fb (access_control_fb),
        .game_fb           (game_fb),
        .scoreboard_fb     (scoreboard_fb),
        .buttons_select    (buttons_select),
        .switches_select   (switches_select),
        .lcd_control       (lcd_control),
        .led_control       (led_control),
        .userid            (userid),
        .game_score_select (game_score_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        buttons = 3'b000;
        access_control_fb = 1'b0;
        game_fb = 1'b0;
        scoreboard_fb = 1'b0;
        #1;
        n_cmp++;
        if (dec !== DEC_ACCESS) begin
            n_bad++;
            $display("FAIL reset_during_dec: got %b exp %b", dec, DEC_ACCESS);
        end
        n_cmp++;
        if (userid !== 16'h0000 || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_during_regs: got %h/%h exp 0000/0", userid, game_score_select);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (dec !== DEC_ACCESS) begin
            n_bad++;
            $display("FAIL reset_after_dec: got %b exp %b", dec, DEC_ACCESS);
        end
        n_cmp++;
        if (userid !== 16'h0000 || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_after_regs: got %h/%h exp 0000/0", userid, game_score_select);
        end
    endtask

    task automatic test_stay_access();
        access_control_fb = 1'b0;
        buttons = 3'b000;
        repeat (5) tick();
        n_cmp++;
        if (dec !== DEC_ACCESS) begin
            n_bad++;
            $display("FAIL stay_fb0: got %b exp %b", dec, DEC_ACCESS);
        end
        access_control_fb = 1'b1;
        buttons = 3'b001;
        repeat (3) tick();
        n_cmp++;
        if (dec !== DEC_ACCESS || userid !== 16'h0000) begin
            n_bad++;
            $display("FAIL stay_fb1_button: got %b uid %h exp %b uid 0000", dec, userid, DEC_ACCESS);
        end
        // Feedbacks of inactive sub-blocks must not move the FSM either.
        access_control_fb = 1'b0;
        buttons = 3'b000;
        game_fb = 1'b1;
        scoreboard_fb = 1'b1;
        tick();
        game_fb = 1'b0;
        scoreboard_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_ACCESS) begin
            n_bad++;
            $display("FAIL stay_foreign_fb: got %b exp %b", dec, DEC_ACCESS);
        end
    endtask

    task automatic test_login();
        access_control_fb = 1'b1;
        buttons = 3'b000;
        tick();
        access_control_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_MENU) begin
            n_bad++;
            $display("FAIL login_dec: got %b exp %b", dec, DEC_MENU);
        end
        n_cmp++;
        if (userid !== 16'h0001 || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL login_regs: got %h/%h exp 0001/0", userid, game_score_select);
        end
    endtask

    task automatic test_menu_dispatch();
        buttons = 3'b001;
        tick();
        n_cmp++;
        if (dec !== DEC_GAME) begin
            n_bad++;
            $display("FAIL menu_to_game: got %b exp %b", dec, DEC_GAME);
        end
        game_fb = 1'b1;
        tick();
        n_cmp++;
        if (dec !== DEC_GAME || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL game_guard: got %b gss %h exp %b gss 0", dec, game_score_select, DEC_GAME);
        end
        buttons = 3'b000;
        tick();
        n_cmp++;
        if (dec !== DEC_MENU || game_score_select !== 4'h1) begin
            n_bad++;
            $display("FAIL game_exit: got %b gss %h exp %b gss 1", dec, game_score_select, DEC_MENU);
        end
        // game_fb still high while in MENU: ignored, nothing counts.
        tick();
        game_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_MENU || game_score_select !== 4'h1) begin
            n_bad++;
            $display("FAIL menu_ignore_fb: got %b gss %h exp %b gss 1", dec, game_score_select, DEC_MENU);
        end
        buttons = 3'b010;
        tick();
        n_cmp++;
        if (dec !== DEC_SCORE) begin
            n_bad++;
            $display("FAIL menu_to_score: got %b exp %b", dec, DEC_SCORE);
        end
        scoreboard_fb = 1'b1;
        tick();
        n_cmp++;
        if (dec !== DEC_SCORE) begin
            n_bad++;
            $display("FAIL score_guard: got %b exp %b", dec, DEC_SCORE);
        end
        buttons = 3'b000;
        tick();
        scoreboard_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_MENU || game_score_select !== 4'h1) begin
            n_bad++;
            $display("FAIL score_exit: got %b gss %h exp %b gss 1", dec, game_score_select, DEC_MENU);
        end
    endtask

    task automatic test_priority_logout();
        buttons = 3'b011;
        tick();
        n_cmp++;
        if (dec !== DEC_GAME) begin
            n_bad++;
            $display("FAIL prio_game_over_score: got %b exp %b", dec, DEC_GAME);
        end
        buttons = 3'b000;
        game_fb = 1'b1;
        tick();
        game_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_MENU || game_score_select !== 4'h2) begin
            n_bad++;
            $display("FAIL second_game: got %b gss %h exp %b gss 2", dec, game_score_select, DEC_MENU);
        end
        buttons = 3'b111;
        tick();
        n_cmp++;
        if (dec !== DEC_ACCESS || userid !== 16'h0001) begin
            n_bad++;
            $display("FAIL logout: got %b uid %h exp %b uid 0001", dec, userid, DEC_ACCESS);
        end
        access_control_fb = 1'b1;
        buttons = 3'b000;
        tick();
        access_control_fb = 1'b0;
        n_cmp++;
        if (dec !== DEC_MENU || userid !== 16'h0002 || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL relogin: got %b uid %h gss %h exp %b uid 0002 gss 0",
                     dec, userid, game_score_select, DEC_MENU);
        end
    endtask

    task automatic test_saturation();
        for (int r = 1; r <= 16; r++) begin
            logic [3:0] exp_gss;
            exp_gss = (r < 15) ? 4'(r) : 4'hF;
            buttons = 3'b001;
            tick();
            buttons = 3'b000;
            game_fb = 1'b1;
            tick();
            game_fb = 1'b0;
            n_cmp++;
            if (dec !== DEC_MENU || game_score_select !== exp_gss) begin
                n_bad++;
                $display("FAIL saturate_round%0d: got %b gss %h exp %b gss %h",
                         r, dec, game_score_select, DEC_MENU, exp_gss);
            end
        end
    endtask

    task automatic test_async_reset();
        buttons = 3'b001;
        tick();
        n_cmp++;
        if (dec !== DEC_GAME) begin
            n_bad++;
            $display("FAIL pre_async_game: got %b exp %b", dec, DEC_GAME);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dec !== DEC_ACCESS || userid !== 16'h0000 || game_score_select !== 4'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %b uid %h gss %h exp %b uid 0000 gss 0",
                     dec, userid, game_score_select, DEC_ACCESS);
        end
        buttons = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (dec !== DEC_ACCESS || userid !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_async: got %b uid %h exp %b uid 0000", dec, userid, DEC_ACCESS);
        end
    endtask

    initial begin
        test_reset();
        test_stay_access();
        test_login();
        test_menu_dispatch();
        test_priority_logout();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
